// File: rtl/mem_pkg.sv
// Shared widths, FSM encoding and memory-control polarity for the burst master.
// No logic and no latency of its own.
// No flow control; types and constants only.
package mem_pkg;

    localparam int MEM_AW = 5;
    localparam int MEM_DW = 8;
    localparam int MEM_LW = 6;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_DRAIN = 3'd2,
        WR       = 3'd3,
        WR_LAST  = 3'd4,
        DONE     = 3'd5
    } state_t;

    // mem_read is a write-enable in disguise: low means read.
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_burst_ctr.sv
// Burst bookkeeping: wrapping address pointer plus remaining-beat count.
// Load and step both take effect on the next rising edge.
// No backpressure; a step with nothing remaining is ignored.
module mem_burst_ctr
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int LW = MEM_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [AW-1:0] load_addr,
    input  logic [LW-1:0] load_len,
    output logic [AW-1:0] ptr,
    output logic [LW-1:0] remaining,
    output logic          last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= load_addr;
            remaining <= load_len;
        end else if (step && (remaining != '0)) begin
            // Pointer wraps naturally at 2**AW.
            ptr       <= ptr + AW'(1);
            remaining <= remaining - LW'(1);
        end
    end

    assign last = (remaining == LW'(1));

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a combinational-read / clocked-write memory.
// Reads: first beat 2 edges after command, then 1 beat/cycle; writes: 1 strobe per beat.
// rd_valid/rd_data hold while rd_ready is low; wr_ready drops after the final beat.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW,
    parameter int LW = MEM_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out,
    output logic          mem_read,
    output logic          done
);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [LW-1:0] remaining;
    logic          last;
    logic          cmd_fire;
    logic          rd_cap;
    logic          wr_fire;

    assign cmd_ready = (state == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    // A read beat is captured whenever the output slot is empty or being drained.
    assign rd_cap    = (state == RD) && (remaining != '0) && (!rd_valid || rd_ready);
    assign wr_fire   = (state == WR) && wr_valid && wr_ready;

    mem_burst_ctr #(
        .AW (AW),
        .LW (LW)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cmd_fire),
        .step      (rd_cap || wr_fire),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .ptr       (ptr),
        .remaining (remaining),
        .last      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_read <= MEM_RD;
            mem_add  <= '0;
            mem_in   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            state <= DONE;
                        end else if (cmd_write) begin
                            state    <= WR;
                            wr_ready <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_add  <= cmd_addr;
                            mem_read <= MEM_RD;
                        end
                    end
                end
                RD: begin
                    if (rd_cap) begin
                        rd_data  <= mem_out;
                        rd_valid <= 1'b1;
                        mem_add  <= ptr + AW'(1);
                        if (last) begin
                            state <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        state    <= DONE;
                    end
                end
                WR: begin
                    if (wr_fire) begin
                        mem_add  <= ptr;
                        mem_in   <= wr_data;
                        mem_read <= MEM_WR;
                        if (last) begin
                            wr_ready <= 1'b0;
                            state    <= WR_LAST;
                        end
                    end else begin
                        mem_read <= MEM_RD;
                    end
                end
                WR_LAST: begin
                    mem_read <= MEM_RD;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= MEM_RD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural memory, directed bursts, then random bursts.
module tb_mem_burst_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [4:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [4:0] mem_add;
    logic [7:0] mem_in;
    logic [7:0] mem_out;
    logic       mem_read;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] mem     [0:31];
    logic [7:0] ref_mem [0:31];
    logic [7:0] wq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory under the master: clocked write, combinational read.
    always @(posedge clk) if (mem_read) mem[mem_add] <= mem_in;
    assign mem_out = mem[mem_add];

    mem_burst_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .mem_add   (mem_add),
        .mem_in    (mem_in),
        .mem_out   (mem_out),
        .mem_read  (mem_read),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic issue_cmd(input bit wr, input int base, input int len, output int hs);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = base[4:0];
        cmd_len   = len[5:0];
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1 hs = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    // rmode: 0 = rd_ready high, 1 = 1,0,0,1,0,1 pattern, 2 = random.  vmode: 0 = wr_valid high, 1 = random.
    task automatic run_burst(input bit wr, input int base, input int len,
                             input int rmode, input int vmode, input string tag);
        logic [7:0] exp_q [$];
        int wlog_a [$];
        int wlog_d [$];
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        int hs, k, widx, n_acc, first_v, first_acc, last_acc, done_lat;
        int mr_cnt, rv_cnt, wrdy_cnt, busy;
        bit got_done, pstall;
        logic [7:0] pdat;

        exp_q = {};
        for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % 32]);
        k = 0; widx = 0; n_acc = 0; first_v = -1; first_acc = -1; last_acc = -1;
        done_lat = -1; mr_cnt = 0; rv_cnt = 0; wrdy_cnt = 0; busy = 0;
        got_done = 0; pstall = 0; pdat = '0;

        issue_cmd(wr, base, len, hs);
        if (!wr && len > 0) chk({tag, "_add0"}, mem_add, base);

        for (int c = 0; c < 400 && !got_done; c++) begin
            if (done) begin
                got_done = 1;
                done_lat = cyc + 1 - hs;
            end else begin
                if (cmd_ready) busy++;
                if (wr_ready) wrdy_cnt++;
                if (rd_valid) rv_cnt++;
                if (mem_read) begin
                    mr_cnt++;
                    wlog_a.push_back(int'(mem_add));
                    wlog_d.push_back(int'(mem_in));
                end
                if (pstall) begin
                    chk({tag, "_stall_vld"}, rd_valid, 1);
                    chk({tag, "_stall_dat"}, rd_data, pdat);
                end
                rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[k % 6] != 0 : 1'($urandom_range(0, 1));
                k++;
                if (rd_valid && first_v < 0) first_v = cyc + 1 - hs;
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() > 0) chk({tag, "_beat"}, rd_data, exp_q.pop_front());
                    n_acc++;
                    if (first_acc < 0) first_acc = cyc + 1;
                    last_acc = cyc + 1;
                end
                pstall = rd_valid && !rd_ready;
                pdat   = rd_data;
                if (wr && widx < len) begin
                    wr_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    wr_data  = wq[widx];
                end else begin
                    wr_valid = 1'($urandom_range(0, 1));
                    wr_data  = 8'($urandom);
                end
                if (wr && wr_valid && wr_ready) begin
                    ref_mem[(base + widx) % 32] = wq[widx];
                    widx++;
                end
                @(negedge clk);
            end
        end
        rd_ready = 1'b0;
        wr_valid = 1'b0;

        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_busy_cmd_ready"}, busy, 0);
        if (len == 0) chk({tag, "_done_lat"}, done_lat, 2);
        if (wr) begin
            chk({tag, "_rd_valid_cnt"}, rv_cnt, 0);
            chk({tag, "_wbeats"}, widx, len);
            chk({tag, "_strobe_cycles"}, mr_cnt, len);
            for (int i = 0; i < wlog_a.size() && i < len; i++) begin
                chk({tag, "_wr_addr"}, wlog_a[i], (base + i) % 32);
                chk({tag, "_wr_data"}, wlog_d[i], wq[i]);
            end
        end else begin
            chk({tag, "_strobe_cycles"}, mr_cnt, 0);
            chk({tag, "_wr_ready_cnt"}, wrdy_cnt, 0);
            chk({tag, "_nbeats"}, n_acc, len);
            if (len == 0) chk({tag, "_rd_valid_cnt"}, rv_cnt, 0);
            if (rmode == 0 && len > 0) begin
                chk({tag, "_first_lat"}, first_v, 2);
                chk({tag, "_span"}, last_acc - first_acc, len - 1);
            end
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, widx, mrc, post_mr;

        for (int i = 0; i < 32; i++) poke(i, 8'($urandom));
        for (int i = 1; i <= 18; i++) poke(i, 8'(i));

        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_add", mem_add, 0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_burst(0, 1, 4, 0, 0, "rd4");
        run_burst(0, 1, 5, 1, 0, "rd_toggle");
        wq = {8'hA5, 8'h5A, 8'h3C};
        run_burst(1, 20, 3, 0, 0, "wr3");
        run_burst(0, 20, 3, 0, 0, "rdback");
        run_burst(0, 7, 0, 0, 0, "rd_len0");
        wq = {};
        run_burst(1, 9, 0, 0, 0, "wr_len0");

        poke(30, 8'hAA); poke(31, 8'hBB); poke(0, 8'hCC); poke(1, 8'hDD);
        run_burst(0, 30, 4, 0, 0, "rd_wrap");

        // Reset while the second of four write beats is on the memory pins.
        wq = {8'h11, 8'h22, 8'h33, 8'h44};
        issue_cmd(1, 8, 4, hs);
        widx = 0;
        mrc = 0;
        for (int c = 0; c < 20 && mrc < 2; c++) begin
            if (mem_read) mrc++;
            if (mrc < 2) begin
                wr_valid = 1'b1;
                wr_data  = wq[widx];
                if (wr_ready) widx++;
                @(negedge clk);
            end
        end
        chk("rst_mid_reached", mrc, 2);
        ref_mem[8] = 8'h11;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_read", mem_read, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_wr_ready", wr_ready, 0);
        chk("rst_mid_mem_add", mem_add, 0);
        post_mr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_read) post_mr++;
        end
        wr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_post_strobes", post_mr, 0);
        chk("rst_rel_cmd_ready", cmd_ready, 1);
        run_burst(0, 8, 4, 0, 0, "rst_readback");

        for (int n = 0; n < 24; n++) begin
            bit w;
            int b, l;
            w = 1'($urandom_range(0, 1));
            b = $urandom_range(0, 31);
            l = (n % 8 == 7) ? 32 : $urandom_range(0, 12);
            wq = {};
            for (int i = 0; i < l; i++) wq.push_back(8'($urandom));
            run_burst(w, b, l, $urandom_range(0, 2), $urandom_range(0, 1), w ? "rnd_wr" : "rnd_rd");
        end

        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the 32x8 combinational-read memory.
- Accepts one burst command: base address, length, direction.
- Drives the memory's address, data and read/write-select pins.
- Read data leaves on a valid/ready stream; write data arrives on a valid/ready stream.
- Sits between the datapath/testbench stimulus and the memory.
- Serialises all memory traffic so the memory never sees uncoordinated reads and writes.

Parameters:
- AW, 5, memory address width; depth is 2**AW.
- DW, 8, data width.
- LW, 6, burst-length field width; legal lengths are 0..2**AW.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  base address.
- cmd_len  in  LW  number of beats.
- rd_data  out  DW  read beat.
- rd_valid  out  1  rd_data holds a valid beat.
- rd_ready  in  1  consumer accepts the read beat.
- wr_data  in  DW  write beat.
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  master accepts the write beat.
- mem_add  out  AW  to memory address, registered.
- mem_in  out  DW  to memory write data, registered.
- mem_out  in  DW  from memory read data (combinational).
- mem_read  out  1  memory control; 0 = read, 1 = write; registered.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - State = IDLE.
  - mem_read = 0 (read, so a write can never occur in reset).
  - mem_add = 0, mem_in = 0, rd_data = 0, rd_valid = 0, wr_ready = 0, done = 0.
  - Address and beat counters = 0.
- Handshake rule: transfer occurs when valid && ready at a rising edge. valid must not depend on ready.
- States: IDLE, RD, RD_DRAIN, WR, WR_LAST, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd handshake: latch addr into ptr, len into remaining.
  - len == 0 -> DONE, with no memory access.
  - cmd_write = 1 -> WR; else -> RD.
- RD:
  - mem_read = 0 and mem_add = ptr (registered, so valid from the entry edge).
  - Each cycle where remaining > 0 and (!rd_valid || rd_ready):
    - capture mem_out (for the address currently on mem_add) into rd_data; set rd_valid = 1;
    - ptr increments, wrapping 2**AW-1 -> 0; remaining decrements;
    - mem_add updates to the next ptr.
  - When the final beat is captured -> RD_DRAIN.
  - Throughput: 1 beat/cycle with rd_ready held high. First rd_valid appears 2 cycles after the cmd handshake edge.
- RD_DRAIN:
  - Holds rd_data/rd_valid stable until rd_ready.
  - On handshake: rd_valid = 0, -> DONE.
- rd_data and rd_valid are held stable while rd_valid && !rd_ready (no loss, no duplication).
- WR:
  - wr_ready = 1 while remaining > 0.
  - On each beat handshake, next edge: mem_add = ptr, mem_in = wr_data, mem_read = 1; ptr wraps and increments; remaining decrements.
  - When no beat is accepted: mem_read = 0 next edge (memory write strobe is exactly one cycle per beat).
  - Last beat accepted -> WR_LAST.
- WR_LAST: the final write is presented for one cycle; mem_read = 0 on exit; -> DONE.
- DONE: done = 1 for exactly one cycle; -> IDLE.
- Address arithmetic is modulo 2**AW. remaining is LW bits; len = 32 is a full-memory sweep.
- cmd_valid asserted outside IDLE is ignored (cmd_ready = 0). rd_ready/wr_valid activity in the wrong state has no effect.
- Reset asserted mid-burst:
  - immediate asynchronous return to reset values;
  - a partially written burst is not rolled back;
  - no further mem_read = 1 after rst_n falls.

Decomposition:
- Shared package mem_pkg:
  - AW/DW/LW defaults;
  - state encoding typedef (IDLE, RD, RD_DRAIN, WR, WR_LAST, DONE);
  - MEM_RD = 0 and MEM_WR = 1 constants for the mem_read polarity.
- One natural sub-module, mem_burst_ctr: wrapping address pointer plus remaining-beat counter, with load/step inputs and a last flag. Everything else stays in mem_burst_master.

Test Plan:
- Read, base 1, len 4, memory preloaded MEMORY[i] = i for i = 1..18, rd_ready = 1 -> rd_data 1,2,3,4 on consecutive cycles; then done pulse; mem_read never 1.
- Read wrap, base 30, len 4, locations 30/31/0/1 preloaded 0xAA/0xBB/0xCC/0xDD -> beats AA, BB, CC, DD; mem_add sequence 30, 31, 0, 1.
- Write, base 20, len 3, data A5/5A/3C with wr_valid continuous -> three one-cycle mem_read = 1 pulses at mem_add 20/21/22; then read back base 20, len 3 -> A5, 5A, 3C.
- Read base 1, len 5 with rd_ready toggling 1,0,0,1,0,1,... -> exactly 1..5 delivered in order; rd_data stable while stalled.
- len = 0 (read and write) -> done 2 cycles after cmd handshake; no mem_read = 1; no rd_valid.
- rst_n low during the 2nd beat of a 4-beat write -> mem_read = 0 immediately; state IDLE; cmd_ready = 1 after release; only the first beat written.
